snn: RTL and testbench

// - Top-level board wrapper: UART receiver + transmitter, 8 LEDs.
// - Receives 8N1 bytes on uart_rx, shows the last good byte on led, and echoes each good byte on uart_tx.
// - Fixed-baud, single clock domain; hosts future classifier logic fed by RX bytes.

---
 rtl/snn_pkg.sv | 16 +
 rtl/snn_uart_rx.sv | 116 +++++++++++
 rtl/snn.sv | 131 +++++++++++++
 tb/tb_snn.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared UART timing defaults and the state encoding used by both serial FSMs.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package snn_pkg;

    localparam int BAUD_DIV_DEF = 2604;  // 100 MHz / 38400 baud
    localparam int HALF_DIV_DEF = 1302;  // start-bit mid-point offset

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

endpackage

// File: rtl/snn_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, framing check on the stop bit.
// Latency: rx_rdy about 2+HALF_DIV+9*BAUD_DIV clocks after the start-bit falling edge.
// Backpressure: none; rx_rdy is a 1-cycle pulse and rx_byte is only meaningful with it.
module uart_rx
    import snn_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEF,
    parameter int HALF_DIV = HALF_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_rdy
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_DIV - 1);

    logic          rx_meta;
    logic          rx_s;
    logic          rx_prev;
    uart_state_t   state;
    uart_state_t   state_nxt;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          sample;
    logic          rdy_nxt;

    // Synchronize the asynchronous line and keep one extra stage for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; the stop bit is judged at its middle and we go idle right away
    // so a following start edge is not missed.
    always_comb begin
        state_nxt = state;
        sample    = 1'b0;
        rdy_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (rx_prev && !rx_s) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (baud_cnt == HALF_LAST) begin
                    state_nxt = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (baud_cnt == BIT_LAST) begin
                    sample = 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (baud_cnt == BIT_LAST) begin
                    state_nxt = IDLE;
                    rdy_nxt   = rx_s;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bit timer, bit index and LSB-first shift register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            rx_rdy   <= 1'b0;
        end else begin
            rx_rdy <= rdy_nxt;
            if (state == IDLE || state_nxt != state || sample) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
            if (state != DATA) begin
                bit_idx <= '0;
            end else if (sample && bit_idx != 3'd7) begin
                bit_idx <= bit_idx + 1'b1;
            end
            if (sample) begin
                shift <= {rx_s, shift[7:1]};
            end
        end
    end

    assign rx_byte = shift;

endmodule

// File: rtl/snn.sv
// Board wrapper: receive 8N1 bytes, show the last good byte on led, echo it on uart_tx.
// Latency: led updates 1 clock after rx_rdy; TX start bit begins 1 clock after rx_rdy.
// Backpressure: none; a byte arriving while TX is busy updates led but is not echoed.
module snn
    import snn_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEF,
    parameter int HALF_DIV = HALF_DIV_DEF
) (
    input  logic       clk,
    input  logic       sys_rst_n,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic [7:0] led
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BIT_LAST = CW'(BAUD_DIV - 1);

    logic [7:0]    rx_byte;
    logic          rx_rdy;
    uart_state_t   tx_state;
    uart_state_t   tx_state_nxt;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_idx;
    logic [7:0]    tx_sh;
    logic          tx_bit_end;
    logic          tx_load;
    logic          tx_shift;
    logic          tx_line_nxt;

    uart_rx #(
        .BAUD_DIV (BAUD_DIV),
        .HALF_DIV (HALF_DIV)
    ) u_rx (
        .clk     (clk),
        .rst_n   (sys_rst_n),
        .rx      (uart_rx),
        .rx_byte (rx_byte),
        .rx_rdy  (rx_rdy)
    );

    // Latch each correctly framed byte for display.
    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            led <= 8'h00;
        end else if (rx_rdy) begin
            led <= rx_byte;
        end
    end

    // TX state register.
    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            tx_state <= IDLE;
        end else begin
            tx_state <= tx_state_nxt;
        end
    end

    // TX next state; the line value is computed here so uart_tx leaves a flop glitch-free.
    always_comb begin
        tx_state_nxt = tx_state;
        tx_load      = 1'b0;
        tx_shift     = 1'b0;
        tx_line_nxt  = uart_tx;
        tx_bit_end   = (tx_cnt == BIT_LAST);
        case (tx_state)
            IDLE: begin
                tx_line_nxt = 1'b1;
                if (rx_rdy) begin
                    tx_state_nxt = START;
                    tx_load      = 1'b1;
                    tx_line_nxt  = 1'b0;
                end
            end
            START: begin
                if (tx_bit_end) begin
                    tx_state_nxt = DATA;
                    tx_line_nxt  = tx_sh[0];
                end
            end
            DATA: begin
                if (tx_bit_end) begin
                    if (tx_idx == 3'd7) begin
                        tx_state_nxt = STOP;
                        tx_line_nxt  = 1'b1;
                    end else begin
                        tx_shift    = 1'b1;
                        tx_line_nxt = tx_sh[1];
                    end
                end
            end
            STOP: begin
                if (tx_bit_end) begin
                    tx_state_nxt = IDLE;
                    tx_line_nxt  = 1'b1;
                end
            end
            default: begin
                tx_state_nxt = IDLE;
                tx_line_nxt  = 1'b1;
            end
        endcase
    end

    // TX bit timer, shift register and registered serial line.
    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            tx_cnt  <= '0;
            tx_idx  <= '0;
            tx_sh   <= '0;
            uart_tx <= 1'b1;
        end else begin
            uart_tx <= tx_line_nxt;
            if (tx_state == IDLE || tx_bit_end) begin
                tx_cnt <= '0;
            end else begin
                tx_cnt <= tx_cnt + 1'b1;
            end
            if (tx_load) begin
                tx_sh  <= rx_byte;
                tx_idx <= '0;
            end else if (tx_shift) begin
                tx_sh  <= {1'b0, tx_sh[7:1]};
                tx_idx <= tx_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_snn.sv
// Directed bench for snn: table of frames plus hand-written glitch and mid-frame reset sequences.
// Timing is scaled down (64 clocks per bit) so the whole run stays short.
// Echoed frames are decoded by a line monitor that also checks every bit lasts exactly one bit time.
module tb_snn;

    localparam int B = 64;
    localparam int H = 32;

    logic       clk;
    logic       sys_rst_n;
    logic       uart_rx;
    logic       uart_tx;
    logic [7:0] led;

    int checks = 0;
    int errors = 0;

    int         tx_starts = 0;
    logic [7:0] mon_q[$];
    logic       mon_ok_q[$];
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic [7:0] exp_led;
        logic       exp_echo;
    } vec_t;

    vec_t vecs[5];

    snn #(
        .BAUD_DIV (B),
        .HALF_DIV (H)
    ) dut (
        .clk       (clk),
        .sys_rst_n (sys_rst_n),
        .uart_rx   (uart_rx),
        .uart_tx   (uart_tx),
        .led       (led)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        uart_rx = 1'b0;
        repeat (B) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            uart_rx = d[k];
            repeat (B) @(negedge clk);
        end
        uart_rx = stop;
        repeat (B) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    // Line monitor: decodes each TX frame, checking start/stop levels and exact bit lengths.
    initial begin : monitor
        logic       mon_prev;
        logic [7:0] b;
        logic       lvl;
        logic       ok;
        logic       aborted;
        mon_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (sys_rst_n === 1'b1 && mon_prev === 1'b1 && uart_tx === 1'b0) begin
                tx_starts++;
                b       = 8'h00;
                ok      = 1'b1;
                aborted = 1'b0;
                lvl     = 1'b0;
                for (int k = 0; k < 10; k++) begin
                    for (int j = 0; j < B; j++) begin
                        if (k != 0 || j != 0) @(negedge clk);
                        if (sys_rst_n !== 1'b1) aborted = 1'b1;
                        if (j == 0) lvl = uart_tx;
                        else if (uart_tx !== lvl) ok = 1'b0;
                    end
                    if (k == 0 && lvl !== 1'b0) ok = 1'b0;
                    if (k == 9 && lvl !== 1'b1) ok = 1'b0;
                    if (k >= 1 && k <= 8) b[k-1] = lvl;
                end
                if (!aborted) begin
                    mon_q.push_back(b);
                    mon_ok_q.push_back(ok);
                end
            end
            mon_prev = uart_tx;
        end
    end

    initial begin : main
        int bad;
        int s0;

        vecs[0] = '{data: 8'hA5, stop_bit: 1'b1, exp_led: 8'hA5, exp_echo: 1'b1};
        vecs[1] = '{data: 8'hE7, stop_bit: 1'b1, exp_led: 8'hE7, exp_echo: 1'b1};
        vecs[2] = '{data: 8'h24, stop_bit: 1'b1, exp_led: 8'h24, exp_echo: 1'b1};
        vecs[3] = '{data: 8'h3C, stop_bit: 1'b0, exp_led: 8'h24, exp_echo: 1'b0};
        vecs[4] = '{data: 8'h81, stop_bit: 1'b1, exp_led: 8'h81, exp_echo: 1'b1};

        // Reset hold then idle: outputs must stay at their idle values throughout.
        sys_rst_n = 1'b0;
        uart_rx   = 1'b1;
        bad       = 0;
        repeat (H) begin
            @(negedge clk);
            if (led !== 8'h00 || uart_tx !== 1'b1) bad++;
        end
        sys_rst_n = 1'b1;
        repeat (H) begin
            @(negedge clk);
            if (led !== 8'h00 || uart_tx !== 1'b1) bad++;
        end
        check("reset_idle", bad, 0);

        // Frame table: led after each frame, and whether an echo was started.
        for (int i = 0; i < 5; i++) begin
            s0 = tx_starts;
            send_frame(vecs[i].data, vecs[i].stop_bit);
            check($sformatf("led_after_%02h", vecs[i].data), led, vecs[i].exp_led);
            check($sformatf("echo_start_%02h", vecs[i].data), tx_starts - s0, vecs[i].exp_echo);
            if (vecs[i].exp_echo) exp_q.push_back(vecs[i].data);
            repeat (H) @(negedge clk);
        end

        // Short low glitch must not start a reception or any TX activity.
        repeat (10 * B) @(negedge clk);
        s0 = tx_starts;
        uart_rx = 1'b0;
        repeat (12) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * B) @(negedge clk);
        check("glitch_led", led, 8'h81);
        check("glitch_tx", tx_starts - s0, 0);

        // Reset mid DATA phase of a new frame while the previous echo is on the line.
        send_frame(8'h66, 1'b1);
        repeat (H) @(negedge clk);
        uart_rx = 1'b0;
        repeat (B) @(negedge clk);
        uart_rx = 1'b0;
        repeat (B) @(negedge clk);
        uart_rx = 1'b1;
        repeat (B) @(negedge clk);
        uart_rx = 1'b0;
        repeat (H) @(negedge clk);
        check("tx_busy_pre_reset", uart_tx, 1'b0);
        sys_rst_n = 1'b0;
        @(negedge clk);
        check("midreset_led", led, 8'h00);
        check("midreset_tx", uart_tx, 1'b1);
        uart_rx = 1'b1;
        repeat (4) @(negedge clk);
        sys_rst_n = 1'b1;
        repeat (B) @(negedge clk);
        send_frame(8'h5A, 1'b1);
        check("led_after_reset_5a", led, 8'h5A);
        exp_q.push_back(8'h5A);

        // Let the last echo finish, then compare all decoded echoes.
        repeat (11 * B) @(negedge clk);
        check("echo_count", mon_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
            check($sformatf("echo_byte_%0d", i), mon_q[i], exp_q[i]);
            check($sformatf("echo_frame_ok_%0d", i), mon_ok_q[i], 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
